// File: rtl/controller_mc.sv
// Multi-cycle RV32I control unit: sequences BOOT/FETCH/DECODE/EXEC/MEM/WB with a
// req/ack memory handshake, a memory-wait watchdog and illegal-instruction trapping.
//
//   state  | meaning
//   BOOT   | post-reset idle cycle, all outputs quiet
//   FETCH  | instruction read pending, IR loads on ack
//   DECODE | field decode and legality check
//   EXEC   | ALU cycle, branches resolve here
//   MEM    | data read/write pending
//   WB     | register write-back and PC update
//   TRAP   | absorbing error state, left only through reset
module controller_mc #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ack,
  input  logic        br_taken,
  output logic        ir_en,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        rfwrite,
  output logic        Use_Imm,
  output logic [1:0]  sel_PC,
  output logic [1:0]  wb_sel,
  output logic [2:0]  Op_Extend,
  output logic [2:0]  br_type,
  output logic [3:0]  ALUop,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state
);

  localparam int CW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam bit WD_ON = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cause_q, cause_d;
  logic [CW-1:0] wd_q, wd_d;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_r, is_i, is_ld, is_st, is_lui, is_auipc, is_br, is_jal, is_jalr;
  logic       illegal;
  logic       f7_ok;
  logic [3:0] alu_base;
  logic       alu_alt;
  logic [2:0] br_code;
  logic       fields_on;
  logic       wd_hit;
  logic       unused_bits;

  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign is_r     = (opcode == 7'h33);
  assign is_i     = (opcode == 7'h13);
  assign is_ld    = (opcode == 7'h03);
  assign is_st    = (opcode == 7'h23);
  assign is_lui   = (opcode == 7'h37);
  assign is_auipc = (opcode == 7'h17);
  assign is_br    = (opcode == 7'h63);
  assign is_jal   = (opcode == 7'h6F);
  assign is_jalr  = (opcode == 7'h67);
  assign f7_ok    = (f7 == 7'h00) || (f7 == 7'h20);
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    illegal = 1'b0;
    case (opcode)
      7'h33: illegal = !f7_ok || ((f7 == 7'h20) && !((f3 == 3'b000) || (f3 == 3'b101)));
      7'h13: begin
        if (f3 == 3'b001)      illegal = (f7 != 7'h00);
        else if (f3 == 3'b101) illegal = !f7_ok;
      end
      7'h63: illegal = (f3 == 3'b010) || (f3 == 3'b011);
      7'h03: illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      7'h23: illegal = (f3 > 3'b010);
      7'h67: illegal = (f3 != 3'b000);
      7'h37, 7'h17, 7'h6F: illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    alu_base = 4'd0;
    case (f3)
      3'b000: alu_base = 4'd0;
      3'b001: alu_base = 4'd2;
      3'b010: alu_base = 4'd3;
      3'b011: alu_base = 4'd4;
      3'b100: alu_base = 4'd5;
      3'b101: alu_base = 4'd6;
      3'b110: alu_base = 4'd8;
      3'b111: alu_base = 4'd9;
      default: alu_base = 4'd0;
    endcase
    // instr[30] turns add->sub (R only) and srl->sra (R and I)
    alu_alt = 1'b0;
    if (is_r)      alu_alt = instr[30] && ((f3 == 3'b000) || (f3 == 3'b101));
    else if (is_i) alu_alt = instr[30] && (f3 == 3'b101);
  end

  always_comb begin
    br_code = 3'd7;
    case (f3)
      3'b000: br_code = 3'd0;
      3'b001: br_code = 3'd1;
      3'b100: br_code = 3'd2;
      3'b101: br_code = 3'd3;
      3'b110: br_code = 3'd4;
      3'b111: br_code = 3'd5;
      default: br_code = 3'd7;
    endcase
  end

  assign fields_on = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                     (state_q == S_MEM) || (state_q == S_WB);

  always_comb begin
    Use_Imm   = 1'b0;
    sel_PC    = 2'd0;
    wb_sel    = 2'd0;
    Op_Extend = 3'd0;
    br_type   = 3'd7;
    ALUop     = 4'd0;
    if (fields_on) begin
      Use_Imm = is_i | is_ld | is_st | is_lui | is_auipc | is_br | is_jal | is_jalr;
      if (is_lui)                         sel_PC = 2'd2;
      else if (is_auipc | is_br | is_jal) sel_PC = 2'd1;
      if (is_st)                 Op_Extend = 3'd1;
      else if (is_lui | is_auipc) Op_Extend = 3'd2;
      else if (is_br)            Op_Extend = 3'd3;
      else if (is_jal)           Op_Extend = 3'd4;
      if (is_jal | is_jalr) br_type = 3'd6;
      else if (is_br)       br_type = br_code;
      if (is_jal | is_jalr) wb_sel = 2'd2;
      else if (is_ld)       wb_sel = 2'd1;
      if (is_r | is_i) ALUop = alu_base + {3'b000, alu_alt};
    end
  end

  assign wd_hit = WD_ON && (wd_q == LIMIT);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    wd_d    = wd_q;
    ir_en   = 1'b0;
    pc_en   = 1'b0;
    pc_sel  = 2'd0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    rfwrite = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        wd_d    = '0;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_en   = 1'b1;
          wd_d    = '0;
          state_d = S_DECODE;
        end else if (wd_hit) begin
          cause_d = 2'd2;
          state_d = S_TRAP;
        end else begin
          wd_d = wd_q + CW'(1);
        end
      end
      S_DECODE: begin
        if (illegal) begin
          cause_d = 2'd1;
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wd_d = '0;
        if (is_br) begin
          pc_en   = 1'b1;
          pc_sel  = {1'b0, br_taken};
          state_d = S_FETCH;
        end else if (is_ld | is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_st;
        if (mem_ack) begin
          wd_d = '0;
          if (is_st) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wd_hit) begin
          cause_d = 2'd3;
          state_d = S_TRAP;
        end else begin
          wd_d = wd_q + CW'(1);
        end
      end
      S_WB: begin
        rfwrite = 1'b1;
        pc_en   = 1'b1;
        if (is_jal)       pc_sel = 2'd1;
        else if (is_jalr) pc_sel = 2'd2;
        wd_d    = '0;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      cause_q <= 2'd0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      wd_q    <= wd_d;
    end
  end

  assign state      = state_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_controller_mc.sv
// Bench for controller_mc: per-cycle comparison against a phase-sequence model,
// a table of hand-derived latency/ALUop vectors, corner sequences and random instructions.
module tb_controller_mc;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        mem_ack = 1'b0;
  logic        br_taken = 1'b0;
  logic        ir_en, pc_en, mem_req, mem_we, rfwrite, Use_Imm, trap;
  logic [1:0]  pc_sel, sel_PC, wb_sel, trap_cause;
  logic [2:0]  Op_Extend, br_type, state;
  logic [3:0]  ALUop;

  controller_mc #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ack(mem_ack), .br_taken(br_taken),
    .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel), .mem_req(mem_req), .mem_we(mem_we),
    .rfwrite(rfwrite), .Use_Imm(Use_Imm), .sel_PC(sel_PC), .wb_sel(wb_sel),
    .Op_Extend(Op_Extend), .br_type(br_type), .ALUop(ALUop), .trap(trap),
    .trap_cause(trap_cause), .state(state)
  );

  always #5 clk = ~clk;

  typedef enum int {P_BOOT = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3,
                    P_MEM = 4, P_WB = 5, P_TRAP = 6} phase_e;
  typedef enum int {C_NONE, C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC} cls_e;

  typedef struct packed {
    logic [2:0] state;
    logic       ir_en;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       mem_req;
    logic       mem_we;
    logic       rfwrite;
    logic       Use_Imm;
    logic [1:0] sel_PC;
    logic [1:0] wb_sel;
    logic [2:0] Op_Extend;
    logic [2:0] br_type;
    logic [3:0] ALUop;
    logic       trap;
    logic [1:0] trap_cause;
  } outs_t;

  typedef struct {
    logic [31:0] ins;
    int          fw;
    int          mw;
    logic        bt;
    int          cyc;
    logic [3:0]  alu;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  function automatic cls_e classify(input logic [31:0] ins);
    case (ins[6:0])
      7'h33: return C_R;
      7'h13: return C_I;
      7'h03: return C_LD;
      7'h23: return C_ST;
      7'h63: return C_BR;
      7'h6F: return C_JAL;
      7'h67: return C_JALR;
      7'h37: return C_LUI;
      7'h17: return C_AUIPC;
      default: return C_NONE;
    endcase
  endfunction

  function automatic bit is_illegal(input logic [31:0] ins);
    logic [2:0] f3;
    logic [6:0] f7;
    bit f7ok;
    f3 = ins[14:12];
    f7 = ins[31:25];
    f7ok = (f7 == 7'h00) || (f7 == 7'h20);
    case (classify(ins))
      C_NONE: return 1'b1;
      C_R:    return !f7ok || (f7 == 7'h20 && !(f3 == 3'd0 || f3 == 3'd5));
      C_I:    return (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && !f7ok);
      C_BR:   return (f3 == 3'd2) || (f3 == 3'd3);
      C_LD:   return (f3 == 3'd3) || (f3 >= 3'd6);
      C_ST:   return (f3 > 3'd2);
      C_JALR: return (f3 != 3'd0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic outs_t exp_out(input phase_e ph, input logic [31:0] ins, input logic ack,
                                    input logic bt, input logic [1:0] cause);
    outs_t o;
    cls_e c;
    logic [2:0] f3;
    int base [8];
    int brmap [8];
    base  = '{0, 2, 3, 4, 5, 6, 8, 9};
    brmap = '{0, 1, 7, 7, 2, 3, 4, 5};
    c  = classify(ins);
    f3 = ins[14:12];
    o = '0;
    o.br_type = 3'd7;
    o.state = 3'(ph);
    if (ph == P_FETCH) begin
      o.mem_req = 1'b1;
      o.ir_en = ack;
    end else if (ph == P_TRAP) begin
      o.trap = 1'b1;
      o.trap_cause = cause;
    end else if (ph != P_BOOT) begin
      o.Use_Imm = (c != C_R) && (c != C_NONE);
      o.sel_PC = (c == C_LUI) ? 2'd2 : (c == C_AUIPC || c == C_BR || c == C_JAL) ? 2'd1 : 2'd0;
      o.Op_Extend = (c == C_ST) ? 3'd1 : (c == C_LUI || c == C_AUIPC) ? 3'd2 :
                    (c == C_BR) ? 3'd3 : (c == C_JAL) ? 3'd4 : 3'd0;
      o.br_type = (c == C_BR) ? 3'(brmap[f3]) : (c == C_JAL || c == C_JALR) ? 3'd6 : 3'd7;
      if (c == C_R)      o.ALUop = 4'(base[f3] + ((ins[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 1 : 0));
      else if (c == C_I) o.ALUop = 4'(base[f3] + ((ins[30] && f3 == 3'd5) ? 1 : 0));
      o.wb_sel = (c == C_JAL || c == C_JALR) ? 2'd2 : (c == C_LD) ? 2'd1 : 2'd0;
      case (ph)
        P_EXEC: if (c == C_BR) begin
          o.pc_en = 1'b1;
          o.pc_sel = {1'b0, bt};
        end
        P_MEM: begin
          o.mem_req = 1'b1;
          o.mem_we = (c == C_ST);
          o.pc_en = (c == C_ST) && ack;
        end
        P_WB: begin
          o.rfwrite = 1'b1;
          o.pc_en = 1'b1;
          o.pc_sel = (c == C_JAL) ? 2'd1 : (c == C_JALR) ? 2'd2 : 2'd0;
        end
        default: ;
      endcase
    end
    return o;
  endfunction

  // Decoded fields of an illegal encoding are not defined; only control is compared.
  function automatic outs_t strip(input outs_t o);
    outs_t r;
    r = o;
    r.pc_sel = 2'd0; r.Use_Imm = 1'b0; r.sel_PC = 2'd0; r.wb_sel = 2'd0;
    r.Op_Extend = 3'd0; r.br_type = 3'd0; r.ALUop = 4'd0;
    return r;
  endfunction

  function automatic outs_t cur();
    outs_t o;
    o.state = state; o.ir_en = ir_en; o.pc_en = pc_en; o.pc_sel = pc_sel;
    o.mem_req = mem_req; o.mem_we = mem_we; o.rfwrite = rfwrite; o.Use_Imm = Use_Imm;
    o.sel_PC = sel_PC; o.wb_sel = wb_sel; o.Op_Extend = Op_Extend; o.br_type = br_type;
    o.ALUop = ALUop; o.trap = trap; o.trap_cause = trap_cause;
    return o;
  endfunction

  task automatic check(input string nm, input outs_t got, input outs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ack = 1'($urandom_range(0, 1));
    #1;
    check("reset", cur(), exp_out(P_BOOT, instr, 1'b0, 1'b0, 2'd0));
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b0;
    #1;
    check("boot", cur(), exp_out(P_BOOT, instr, 1'b0, 1'b0, 2'd0));
  endtask

  // Builds the expected phase sequence for one instruction and checks every cycle.
  task automatic do_instr(input logic [31:0] ins, input int fw, input int mw, input logic bt,
                          output int cyc, output logic [3:0] alu, output logic [1:0] cause);
    phase_e q[$];
    phase_e ph;
    cls_e c;
    bit ill;
    int k;
    logic ack, btd;
    outs_t e;
    c = classify(ins);
    ill = is_illegal(ins);
    cause = 2'd0;
    cyc = 0;
    alu = 4'd0;
    k = 0;
    repeat ((fw > TO) ? TO + 1 : fw + 1) q.push_back(P_FETCH);
    if (fw > TO) cause = 2'd2;
    else begin
      q.push_back(P_DECODE);
      if (ill) cause = 2'd1;
      else begin
        q.push_back(P_EXEC);
        if (c == C_LD || c == C_ST) begin
          repeat ((mw > TO) ? TO + 1 : mw + 1) q.push_back(P_MEM);
          if (mw > TO) cause = 2'd3;
          else if (c == C_LD) q.push_back(P_WB);
        end else if (c != C_BR) q.push_back(P_WB);
      end
    end
    if (cause != 2'd0) repeat (3) q.push_back(P_TRAP);
    for (int i = 0; i < q.size(); i++) begin
      ph = q[i];
      if (i > 0 && q[i-1] == ph) k++;
      else k = 0;
      @(negedge clk);
      if (i == 0) instr = ins;
      if (ph == P_FETCH)    ack = (k == fw);
      else if (ph == P_MEM) ack = (k == mw);
      else                  ack = 1'($urandom_range(0, 1));
      btd = (ph == P_EXEC) ? bt : 1'($urandom_range(0, 1));
      mem_ack = ack;
      br_taken = btd;
      #1;
      e = exp_out(ph, ins, ack, btd, cause);
      if (ill && ph == P_DECODE)
        check($sformatf("cycle %0d of %h", i, ins), strip(cur()), strip(e));
      else
        check($sformatf("cycle %0d of %h", i, ins), cur(), e);
      if (ph == P_DECODE) alu = ALUop;
      if (pc_en && cyc == 0) cyc = i + 1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67, 7'h0B};
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 9)];
    case ($urandom_range(0, 3))
      0, 1: r[31:25] = 7'h00;
      2: r[31:25] = 7'h20;
      default: ;
    endcase
    return r;
  endfunction

  vec_t tbl [14];
  int cyc;
  logic [3:0] alu;
  logic [1:0] cause;
  int fw, mw;

  initial begin
    tbl[0]  = '{32'h002081B3, 0, 0, 1'b0, 4, 4'd0};  // add
    tbl[1]  = '{32'h40108093, 0, 0, 1'b0, 4, 4'd0};  // addi with instr[30]=1
    tbl[2]  = '{32'h4010D093, 0, 0, 1'b0, 4, 4'd7};  // srai
    tbl[3]  = '{32'h0000A183, 0, 3, 1'b0, 8, 4'd0};  // lw, 3 wait cycles
    tbl[4]  = '{32'h00208463, 0, 0, 1'b1, 3, 4'd0};  // beq taken
    tbl[5]  = '{32'h00208463, 0, 0, 1'b0, 3, 4'd0};  // beq not taken
    tbl[6]  = '{32'h000080E7, 0, 0, 1'b0, 4, 4'd0};  // jalr
    tbl[7]  = '{32'h0020A223, 0, 2, 1'b0, 6, 4'd0};  // sw, 2 wait cycles
    tbl[8]  = '{32'h402081B3, 0, 0, 1'b0, 4, 4'd1};  // sub
    tbl[9]  = '{32'h002081B3, 4, 0, 1'b0, 8, 4'd0};  // fetch ack on the limit cycle
    tbl[10] = '{32'h0000A183, 0, 4, 1'b0, 9, 4'd0};  // data ack on the limit cycle
    tbl[11] = '{32'h008000EF, 0, 0, 1'b0, 4, 4'd0};  // jal
    tbl[12] = '{32'h002091B3, 1, 0, 1'b0, 5, 4'd2};  // sll, 1 fetch wait
    tbl[13] = '{32'h0020F1B3, 0, 0, 1'b0, 4, 4'd9};  // and

    do_reset();
    for (int i = 0; i < 14; i++) begin
      do_instr(tbl[i].ins, tbl[i].fw, tbl[i].mw, tbl[i].bt, cyc, alu, cause);
      vectors++;
      if (cyc != tbl[i].cyc || alu !== tbl[i].alu) begin
        miscompares++;
        $display("FAIL tbl[%0d] latency/ALUop: got %0d/%0d required %0d/%0d",
                 i, cyc, alu, tbl[i].cyc, tbl[i].alu);
      end
      if (cause != 2'd0) do_reset();
    end

    // illegal opcode 0x0B traps with cause 1 and issues no further requests
    do_instr(32'h0000000B, 0, 0, 1'b0, cyc, alu, cause);
    vectors++;
    if ({trap, trap_cause, mem_req} !== 4'b1_01_0) begin
      miscompares++;
      $display("FAIL illegal trap: got %b required 1010", {trap, trap_cause, mem_req});
    end
    do_reset();

    // fetch timeout: 5 FETCH cycles with ack low, then TRAP cause 2
    do_instr(32'h002081B3, TO + 1, 0, 1'b0, cyc, alu, cause);
    vectors++;
    if ({state, trap, trap_cause} !== 6'b110_1_10) begin
      miscompares++;
      $display("FAIL fetch timeout: got %b required 110110", {state, trap, trap_cause});
    end
    do_reset();

    // data timeout on a load: TRAP cause 3
    do_instr(32'h0000A183, 0, TO + 1, 1'b0, cyc, alu, cause);
    vectors++;
    if (trap_cause !== 2'd3) begin
      miscompares++;
      $display("FAIL data timeout: got cause %0d required 3", trap_cause);
    end
    do_reset();

    // reset asserted mid-instruction takes effect without a clock edge
    @(negedge clk);
    instr = 32'h002081B3;
    mem_ack = 1'b1;
    #1 check("midrst fetch", cur(), exp_out(P_FETCH, instr, 1'b1, 1'b0, 2'd0));
    @(negedge clk);
    mem_ack = 1'b0;
    #1 check("midrst decode", cur(), exp_out(P_DECODE, instr, 1'b0, 1'b0, 2'd0));
    @(negedge clk);
    #1 check("midrst exec", cur(), exp_out(P_EXEC, instr, 1'b0, 1'b0, 2'd0));
    #1 rst_n = 1'b0;
    #1 check("midrst async", cur(), exp_out(P_BOOT, instr, 1'b0, 1'b0, 2'd0));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst boot", cur(), exp_out(P_BOOT, instr, 1'b0, 1'b0, 2'd0));
    @(negedge clk);
    #1 check("midrst first req", cur(), exp_out(P_FETCH, instr, 1'b0, 1'b0, 2'd0));
    do_reset();

    for (int n = 0; n < 200; n++) begin
      fw = ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(0, TO);
      mw = ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(0, TO);
      do_instr(rand_instr(), fw, mw, 1'($urandom_range(0, 1)), cyc, alu, cause);
      if (cause != 2'd0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
